// File: rtl/dmem_access_controller_pkg.sv
// rtl/dmem_access_controller_pkg.sv - shared constants, FSM encoding and access-size helper for the data-memory master
package dmem_access_controller_pkg;

  // Access size/sign codes carried on mem_funct3
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int DEF_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  // Reserved funct3 codes fall through to a full-word access
  function automatic size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/dmem_access_controller_if.sv
// rtl/dmem_access_controller_if.sv - req/ack data-memory bus between the MEM-stage master and memory
interface dmem_access_controller_if #(
  parameter int ADDR_W = 32
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wdata;
  logic [3:0]        bus_wstrb;
  logic              bus_error;
  logic              bus_ack;
  logic [31:0]       bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, bus_error,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, bus_error,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - combinational store lane replication, load extraction/extension and misalignment detect
module dmem_lane_align
  import dmem_access_controller_pkg::*;
(
  input  logic [2:0]  req_funct3,
  input  logic [1:0]  req_off,
  input  logic [31:0] req_wdata,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_wstrb,
  output logic        misaligned,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shift;

  // Store side: replicate the datum into every lane and enable only the addressed bytes
  always_comb begin
    st_wstrb   = 4'b1111;
    st_wdata   = req_wdata;
    misaligned = 1'b0;
    case (f3_size(req_funct3))
      SZ_B: begin
        st_wstrb = 4'b0001 << req_off;
        st_wdata = {4{req_wdata[7:0]}};
      end
      SZ_H: begin
        st_wstrb   = 4'b0011 << req_off;
        st_wdata   = {2{req_wdata[15:0]}};
        misaligned = req_off[0];
      end
      default: begin
        misaligned = (req_off != 2'b00);
      end
    endcase
  end

  // Load side: bring the addressed lane down to bit 0, then sign- or zero-extend
  always_comb begin
    ld_shift = ld_rdata >> {ld_off, 3'b000};
    case (f3_size(ld_funct3))
      SZ_B:    ld_data = ld_funct3[2] ? {24'b0, ld_shift[7:0]}
                                      : {{24{ld_shift[7]}}, ld_shift[7:0]};
      SZ_H:    ld_data = ld_funct3[2] ? {16'b0, ld_shift[15:0]}
                                      : {{16{ld_shift[15]}}, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

endmodule

// File: rtl/dmem_access_controller.sv
// rtl/dmem_access_controller.sv - MEM-stage data-memory master (optional bus timeout via BUS_TIMEOUT_EN)
module dmem_access_controller
  import dmem_access_controller_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        mem_funct3,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              memory_busy,
  output logic              misaligned,
  dmem_access_controller_if.master bus
);

  state_e            state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  logic [3:0]        bus_wstrb_q, bus_wstrb_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  // Load shape is latched so pipeline input changes during WAIT cannot corrupt extraction
  logic [2:0]        ld_funct3_q, ld_funct3_d;
  logic [1:0]        ld_off_q, ld_off_d;

  logic [31:0]       st_wdata;
  logic [3:0]        st_wstrb;
  logic              mis_raw;
  logic [31:0]       ld_data;
  logic              req_any;
  logic              req_valid;

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bus_error_q, bus_error_d;
`endif

  dmem_lane_align u_lane_align (
    .req_funct3 (mem_funct3),
    .req_off    (mem_addr[1:0]),
    .req_wdata  (mem_wdata),
    .st_wdata   (st_wdata),
    .st_wstrb   (st_wstrb),
    .misaligned (mis_raw),
    .ld_funct3  (ld_funct3_q),
    .ld_off     (ld_off_q),
    .ld_rdata   (bus.bus_rdata),
    .ld_data    (ld_data)
  );

  assign req_any     = mem_read | mem_write;
  assign misaligned  = req_any & mis_raw;
  assign req_valid   = req_any & ~mis_raw;
  assign memory_busy = ((state_q == S_IDLE) & req_valid) | (state_q == S_WAIT);

  assign mem_rdata     = mem_rdata_q;
  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign bus.bus_wstrb = bus_wstrb_q;

`ifdef BUS_TIMEOUT_EN
  assign bus.bus_error = bus_error_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign bus.bus_error  = 1'b0;
`endif

  // Next-state and registered-output logic for the IDLE/WAIT/DONE transaction FSM
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wstrb_d = bus_wstrb_q;
    mem_rdata_d = mem_rdata_q;
    ld_funct3_d = ld_funct3_q;
    ld_off_d    = ld_off_q;
`ifdef BUS_TIMEOUT_EN
    cnt_d       = cnt_q;
    bus_error_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d     = S_WAIT;
          bus_req_d   = 1'b1;
          bus_we_d    = ~mem_read;  // a simultaneous read takes priority
          bus_addr_d  = {mem_addr[ADDR_W-1:2], 2'b00};
          bus_wdata_d = st_wdata;
          bus_wstrb_d = mem_read ? 4'b0000 : st_wstrb;
          ld_funct3_d = mem_funct3;
          ld_off_d    = mem_addr[1:0];
`ifdef BUS_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      S_WAIT: begin
        if (bus.bus_ack) begin
          state_d   = S_DONE;
          bus_req_d = 1'b0;
          if (!bus_we_q) begin
            mem_rdata_d = ld_data;
          end
        end
`ifdef BUS_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = S_DONE;
          bus_req_d   = 1'b0;
          bus_error_d = 1'b1;
          mem_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  // State and bus-field registers; reset aborts any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wstrb_q <= '0;
      mem_rdata_q <= '0;
      ld_funct3_q <= '0;
      ld_off_q    <= '0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wstrb_q <= bus_wstrb_d;
      mem_rdata_q <= mem_rdata_d;
      ld_funct3_q <= ld_funct3_d;
      ld_off_q    <= ld_off_d;
    end
  end

`ifdef BUS_TIMEOUT_EN
  // Wait-cycle counter and single-cycle abort pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      bus_error_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      bus_error_q <= bus_error_d;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_access_controller.sv
// tb/tb_dmem_access_controller.sv - self-checking bench for dmem_access_controller
module tb_dmem_access_controller;
  import dmem_access_controller_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  mem_funct3 = 3'b000;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [31:0] mem_rdata;
  logic        memory_busy;
  logic        misaligned;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_rdata = 32'h0;

  dmem_access_controller_if #(.ADDR_W(32)) bus_if ();

  dmem_access_controller #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_funct3  (mem_funct3),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .memory_busy (memory_busy),
    .misaligned  (misaligned),
    .bus         (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int f3_bytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] exp_strb(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] s;
    int n;
    s = 4'b0000;
    n = f3_bytes(f3);
    for (int i = 0; i < 4; i++)
      if (i >= int'(off) && i < int'(off) + n) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    int n;
    n = f3_bytes(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [31:0] v, mask;
    int n;
    n = f3_bytes(f3);
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*n)) - 32'd1);
    v = (word >> (8*int'(off))) & mask;
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rword, input int waits, input string tag);
    int n, busy, nwait, cyc;
    logic mis;
    n = f3_bytes(f3);
    mis = (int'(addr[1:0]) % n) != 0;
    @(negedge clk);
    mem_read = rd; mem_write = wr; mem_funct3 = f3; mem_addr = addr; mem_wdata = wd;
    bus_if.bus_ack = 1'b0;
    #1;
    chk({tag, " misaligned"}, 32'(misaligned), 32'(mis));
    if (mis) begin
      chk({tag, " mis busy"}, 32'(memory_busy), 32'd0);
      repeat (3) begin
        @(negedge clk); #1;
        chk({tag, " mis bus_req"}, 32'(bus_if.bus_req), 32'd0);
        chk({tag, " mis busy hold"}, 32'(memory_busy), 32'd0);
      end
      mem_read = 1'b0; mem_write = 1'b0;
      return;
    end
    busy = 0; nwait = 0; cyc = 0;
    while (memory_busy === 1'b1 && cyc < 200) begin
      busy++;
      if (bus_if.bus_req === 1'b1) begin
        chk({tag, " bus_addr"}, bus_if.bus_addr, {addr[31:2], 2'b00});
        chk({tag, " bus_we"}, 32'(bus_if.bus_we), 32'(wr && !rd));
        if (!rd) begin
          chk({tag, " bus_wstrb"}, 32'(bus_if.bus_wstrb), 32'(exp_strb(f3, addr[1:0])));
          chk({tag, " bus_wdata"}, bus_if.bus_wdata, exp_wdata(f3, wd));
        end
        mem_addr = $urandom; mem_wdata = $urandom; mem_funct3 = 3'($urandom);
        bus_if.bus_rdata = (nwait == waits) ? rword : $urandom;
        bus_if.bus_ack = (nwait == waits);
        nwait++;
      end
      @(negedge clk);
      bus_if.bus_ack = 1'b0;
      #1;
      cyc++;
    end
    chk({tag, " busy cycles"}, 32'(busy), 32'(waits + 2));
    chk({tag, " done bus_req"}, 32'(bus_if.bus_req), 32'd0);
    if (rd) last_rdata = exp_load(f3, addr[1:0], rword);
    chk({tag, " mem_rdata"}, mem_rdata, last_rdata);
    chk({tag, " bus_error"}, 32'(bus_if.bus_error), 32'd0);
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] rd_f3 [5];
    logic [2:0] f3;
    int sel;
    rd_f3[0] = F3_B; rd_f3[1] = F3_H; rd_f3[2] = F3_W; rd_f3[3] = F3_BU; rd_f3[4] = F3_HU;
    bus_if.bus_ack = 1'b0;
    bus_if.bus_rdata = 32'h0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst bus_req", 32'(bus_if.bus_req), 32'd0);
    chk("rst bus_we", 32'(bus_if.bus_we), 32'd0);
    chk("rst bus_addr", bus_if.bus_addr, 32'd0);
    chk("rst bus_wdata", bus_if.bus_wdata, 32'd0);
    chk("rst bus_wstrb", 32'(bus_if.bus_wstrb), 32'd0);
    chk("rst mem_rdata", mem_rdata, 32'd0);
    chk("rst bus_error", 32'(bus_if.bus_error), 32'd0);
    chk("rst busy", 32'(memory_busy), 32'd0);
    rst_n = 1'b1;

    access(1'b1, 1'b0, F3_W,  32'h100, 32'h0,        32'hDEADBEEF, 0, "lw_100");
    access(1'b0, 1'b1, F3_B,  32'h203, 32'h000000A5, 32'h0,        3, "sb_203");
    access(1'b1, 1'b0, F3_B,  32'h001, 32'h0,        32'h000080FF, 1, "lb_001");
    access(1'b1, 1'b0, F3_HU, 32'h002, 32'h0,        32'h80010000, 0, "lhu_002");
    access(1'b1, 1'b0, F3_W,  32'h102, 32'h0,        32'h0,        0, "lw_102");
    access(1'b0, 1'b1, F3_H,  32'h302, 32'h1234ABCD, 32'h0,        2, "sh_302");
    access(1'b1, 1'b1, F3_H,  32'h406, 32'hFFFFFFFF, 32'h7FFF8000, 1, "rw_both");
    access(1'b0, 1'b1, 3'b111, 32'h50C, 32'hCAFEF00D, 32'h0,       0, "sw_resv");

    // Reset while a read is waiting for ack, then a stray ack in IDLE
    @(negedge clk);
    mem_read = 1'b1; mem_funct3 = F3_W; mem_addr = 32'h300;
    @(negedge clk); #1;
    chk("mid wait bus_req", 32'(bus_if.bus_req), 32'd1);
    mem_read = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid rst bus_req", 32'(bus_if.bus_req), 32'd0);
    chk("mid rst busy", 32'(memory_busy), 32'd0);
    chk("mid rst bus_addr", bus_if.bus_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_if.bus_ack = 1'b1;
    bus_if.bus_rdata = 32'h13579BDF;
    @(negedge clk);
    bus_if.bus_ack = 1'b0;
    #1;
    chk("stray ack bus_req", 32'(bus_if.bus_req), 32'd0);
    chk("stray ack busy", 32'(memory_busy), 32'd0);
    chk("stray ack mem_rdata", mem_rdata, 32'd0);
    last_rdata = 32'h0;

    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 2);
      if (sel == 1) f3 = 3'($urandom_range(0, 7));
      else          f3 = rd_f3[$urandom_range(0, 4)];
      access(sel != 1, sel != 0, f3, $urandom, $urandom, $urandom,
             $urandom_range(0, 3), $sformatf("rand%0d", k));
    end

`ifdef BUS_TIMEOUT_EN
    @(negedge clk);
    mem_read = 1'b1; mem_funct3 = F3_W; mem_addr = 32'h40;
    repeat (4) @(negedge clk);
    #1;
    chk("to last wait busy", 32'(memory_busy), 32'd1);
    chk("to last wait error", 32'(bus_if.bus_error), 32'd0);
    @(negedge clk); #1;
    chk("to error pulse", 32'(bus_if.bus_error), 32'd1);
    chk("to busy released", 32'(memory_busy), 32'd0);
    chk("to bus_req", 32'(bus_if.bus_req), 32'd0);
    chk("to mem_rdata", mem_rdata, 32'd0);
    mem_read = 1'b0;
    @(negedge clk); #1;
    chk("to error cleared", 32'(bus_if.bus_error), 32'd0);
`endif

    access(1'b1, 1'b0, F3_B, 32'h7, 32'h0, 32'h7F000000, 0, "lb_final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_access_controller.md
Name: dmem_access_controller

Overview:
- MEM-stage data-memory master. Converts pipeline load/store requests into a req/ack bus transaction.
- Produces the `memory_busy` stall event that the stall controller consumes. This block is the producer end of that signal.
- Performs byte-lane alignment for stores and sign/zero extension for loads.
- Sits between the MEM stage and the external data memory or bus.

Parameters:
- ADDR_W, 32, byte-address width.
- TIMEOUT_CYCLES, 255, maximum wait for `bus_ack` before abort. Used only with BUS_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mem_read  in  1  MEM-stage load request.
- mem_write  in  1  MEM-stage store request.
- mem_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- mem_addr  in  ADDR_W  byte address.
- mem_wdata  in  32  store data, LSB-justified.
- mem_rdata  out  32  extended load result; valid in DONE.
- memory_busy  out  1  1 = stall pipeline.
- misaligned  out  1  request is misaligned; no bus access is made.
- bus_req  out  1  transaction request.
- bus_we  out  1  1 = write.
- bus_addr  out  ADDR_W  word-aligned address, {addr[ADDR_W-1:2], 2'b00}.
- bus_wdata  out  32  lane-replicated store data.
- bus_wstrb  out  4  byte enables.
- bus_ack  in  1  transaction complete; read data valid on `bus_rdata`.
- bus_rdata  in  32  raw word read.
- bus_error  out  1  timeout abort pulse. Tied to 0 without BUS_TIMEOUT_EN.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values: state IDLE; bus_req, bus_we, bus_wstrb, bus_addr, bus_wdata all 0; mem_rdata 0; bus_error 0.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - A valid aligned request (mem_read or mem_write) moves the FSM to WAIT.
  - On that transition, register bus_req=1 and latch bus_we, bus_addr, bus_wdata and bus_wstrb.
- WAIT:
  - Hold all bus outputs stable until `bus_ack`.
  - On `bus_ack`: capture the extended `bus_rdata` into mem_rdata (reads only), drop bus_req, go to DONE.
- DONE: unconditional return to IDLE; mem_rdata is held.
- memory_busy (combinational):
  - 1 when (IDLE and valid aligned request) or WAIT.
  - 0 in DONE, which lets the instruction retire at that edge.
- Latency:
  - Zero-wait ack (ack in first WAIT cycle) gives 2 stall cycles.
  - Each additional wait cycle adds 1 stall cycle.
- Back-to-back accesses: a new request seen in IDLE immediately after DONE starts a new transaction. There is no lost cycle beyond DONE.
- Request stability: mem_* inputs must remain stable while memory_busy=1. Changes in WAIT are ignored, because the bus fields are latched.
- Both mem_read and mem_write asserted: the read wins and the write is ignored.
- Store lanes:
  - SB: wstrb = 0001 << addr[1:0]; wdata = {4{byte}}.
  - SH: wstrb = 0011 << addr[1:0]; wdata = {2{half}}.
  - SW: wstrb = 1111.
  - Reserved funct3 values are treated as W.
- Load extraction: select the byte/half by addr[1:0]. funct3 000/001 sign-extend; 100/101 zero-extend.
- Misalignment:
  - Defined as H with addr[0]=1, or W with addr[1:0]≠0.
  - misaligned=1 combinationally; memory_busy=0; no bus transaction; FSM stays in IDLE.
- Reset mid-transaction: asynchronous return to IDLE; bus_req drops immediately. A late `bus_ack` arriving in IDLE is ignored.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- With the macro defined:
  - An 8+-bit counter clears on entry to WAIT and increments each WAIT cycle without ack.
  - On reaching TIMEOUT_CYCLES: drop bus_req, pulse bus_error for 1 cycle, go to DONE with mem_rdata=0.
  - An ack in the same cycle as the timeout wins (normal completion).
- Without the macro: no counter, bus_error tied to 0, and WAIT persists indefinitely.

Decomposition:
- Shared package/header:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - FSM state encodings (S_IDLE, S_WAIT, S_DONE).
  - Default TIMEOUT_CYCLES.
- Sub-module `dmem_lane_align`, purely combinational:
  - Store path: wstrb and wdata replication.
  - Load path: extraction and extension.
  - Misalignment detect.
  - Instantiated once; the FSM, counter and registers stay in the top module.

Test Plan:
- LW addr 0x100, ack on first WAIT cycle, bus_rdata 0xDEADBEEF -> memory_busy high exactly 2 cycles; DONE mem_rdata 0xDEADBEEF; bus_addr 0x100, bus_we 0.
- SB addr 0x203, wdata 0x000000A5, ack after 3 wait cycles -> bus_wstrb 1000, bus_wdata 0xA5A5A5A5, bus_addr 0x200, busy for 5 cycles.
- LB addr 0x01 with rdata 0x0000_80FF -> mem_rdata 0xFFFFFF80. LHU addr 0x02 with rdata 0x8001_0000 -> 0x00008001.
- LW addr 0x102 -> misaligned=1, memory_busy=0, bus_req never asserted.
- rst_n low while in WAIT -> bus_req 0 immediately, FSM IDLE; a subsequent stray bus_ack produces no state change.
- BUS_TIMEOUT_EN with TIMEOUT_CYCLES=4 and no ack -> bus_error 1-cycle pulse after 4 WAIT cycles, mem_rdata 0, memory_busy released the next cycle.
